// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - T-state ring controller driving bus enables and register strobes.
// Optional BUS_SEQUENCER_EARLY_FINISH_EN: return to T1 after the last state that carries a strobe.
module bus_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic [3:0] opcode,
    output logic       pc_en,
    output logic       mem_en,
    output logic       ir_en,
    output logic       a_en,
    output logic       adder_en,
    output logic       mar_ld,
    output logic       ir_ld,
    output logic       a_ld,
    output logic       b_ld,
    output logic       out_ld,
    output logic       pc_inc,
    output logic       sub,
    output logic       halt,
    output logic [5:0] t_state
);

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t state_q, state_d;

    logic is_lda, is_add, is_sub, is_out, is_hlt;
    logic strobe_ok;
    logic pc_en_r, mem_en_r, ir_en_r, a_en_r, adder_en_r;
    logic mar_ld_r, ir_ld_r, a_ld_r, b_ld_r, out_ld_r, pc_inc_r, sub_r;

    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (step_en) begin
            case (state_q)
                ST_T1: state_d = ST_T2;
                ST_T2: state_d = ST_T3;
                ST_T3: state_d = ST_T4;
                ST_T4: begin
                    if (is_hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_T5;
`ifdef BUS_SEQUENCER_EARLY_FINISH_EN
                        // OUT and NOP have nothing left to do after T4
                        if (!(is_lda || is_add || is_sub)) begin
                            state_d = ST_T1;
                        end
`endif
                    end
                end
                ST_T5: begin
                    state_d = ST_T6;
`ifdef BUS_SEQUENCER_EARLY_FINISH_EN
                    if (is_lda) begin
                        state_d = ST_T1;
                    end
`endif
                end
                ST_T6:   state_d = ST_T1;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_T1;
            endcase
        end
    end

    always_comb begin
        pc_en_r    = 1'b0;
        mem_en_r   = 1'b0;
        ir_en_r    = 1'b0;
        a_en_r     = 1'b0;
        adder_en_r = 1'b0;
        mar_ld_r   = 1'b0;
        ir_ld_r    = 1'b0;
        a_ld_r     = 1'b0;
        b_ld_r     = 1'b0;
        out_ld_r   = 1'b0;
        pc_inc_r   = 1'b0;
        sub_r      = 1'b0;
        case (state_q)
            ST_T1: begin
                pc_en_r  = 1'b1;
                mar_ld_r = 1'b1;
            end
            ST_T2: pc_inc_r = 1'b1;
            ST_T3: begin
                mem_en_r = 1'b1;
                ir_ld_r  = 1'b1;
            end
            ST_T4: begin
                if (is_lda || is_add || is_sub) begin
                    ir_en_r  = 1'b1;
                    mar_ld_r = 1'b1;
                end else if (is_out) begin
                    a_en_r   = 1'b1;
                    out_ld_r = 1'b1;
                end
            end
            ST_T5: begin
                if (is_lda) begin
                    mem_en_r = 1'b1;
                    a_ld_r   = 1'b1;
                end else if (is_add || is_sub) begin
                    mem_en_r = 1'b1;
                    b_ld_r   = 1'b1;
                end
            end
            ST_T6: begin
                if (is_add || is_sub) begin
                    adder_en_r = 1'b1;
                    a_ld_r     = 1'b1;
                    sub_r      = is_sub;
                end
            end
            default: ;
        endcase
    end

    // Reset is applied combinationally too, so nothing leaks out while rst_n is low.
    assign strobe_ok = step_en & rst_n;

    assign pc_en    = pc_en_r    & strobe_ok;
    assign mem_en   = mem_en_r   & strobe_ok;
    assign ir_en    = ir_en_r    & strobe_ok;
    assign a_en     = a_en_r     & strobe_ok;
    assign adder_en = adder_en_r & strobe_ok;
    assign mar_ld   = mar_ld_r   & strobe_ok;
    assign ir_ld    = ir_ld_r    & strobe_ok;
    assign a_ld     = a_ld_r     & strobe_ok;
    assign b_ld     = b_ld_r     & strobe_ok;
    assign out_ld   = out_ld_r   & strobe_ok;
    assign pc_inc   = pc_inc_r   & strobe_ok;
    assign sub      = sub_r      & strobe_ok;

    assign halt = rst_n & (state_q == ST_HALT);

    always_comb begin
        t_state = 6'b000000;
        if (rst_n && state_q != ST_HALT) begin
            t_state[state_q] = 1'b1;
        end
    end

endmodule
